// File: rtl/peripheral_msi_slice_wb.sv
// Registered Wishbone classic slice with bus watchdog.
// Sits between the MSI arbiter and the slave/decoder: every request field and
// every response is registered, one transfer is outstanding at a time, and
// burst hints are discarded so each beat becomes an independent classic cycle.
// A watchdog terminates a cycle with an error if the slave never answers.

module peripheral_msi_slice_wb #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    // upstream side (from the arbiter)
    input  logic [AW-1:0] wbm_adr_i,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [DW-1:0] wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,

    // downstream side (to the slave/decoder)
    output logic [AW-1:0] wbs_adr_o,
    output logic [DW-1:0] wbs_dat_o,
    output logic [3:0]    wbs_sel_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [DW-1:0] wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i,

    output logic          timeout_o
);

    // Timer width is derived from TIMEOUT and must not be overridden.
    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMR_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          start;     // request accepted in IDLE
    logic          term;      // slave termination accepted in REQ
    logic          fire;      // watchdog expiry in REQ
    logic [TW-1:0] timer;
    logic          req_q;
    logic          ack_q;
    logic          err_q;
    logic          rty_q;
    logic          tmo_q;

    // Burst hints are deliberately dropped; this keeps them visibly consumed.
    logic unused_burst;
    assign unused_burst = ^{wbm_cti_i, wbm_bte_i};

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort beats termination, termination beats watchdog
    always_comb begin
        state_next = state;
        start      = 1'b0;
        term       = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!wbm_cyc_i) begin
                    state_next = IDLE;
                end else if (wbs_ack_i || wbs_err_i || wbs_rty_i) begin
                    term       = 1'b1;
                    state_next = RESP;
                end else if ((TIMEOUT != 0) && (timer == TMR_LAST)) begin
                    fire       = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request registers, watchdog timer and registered response flags
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_sel_o <= '0;
            wbs_we_o  <= 1'b0;
            wbm_dat_o <= '0;
            timer     <= '0;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            // The strobe register mirrors "next state is REQ", so it rises
            // one cycle after acceptance and drops on the exit edge.
            req_q <= (state_next == REQ);

            if (start) begin
                wbs_adr_o <= wbm_adr_i;
                wbs_dat_o <= wbm_dat_i;
                wbs_sel_o <= wbm_sel_i;
                wbs_we_o  <= wbm_we_i;
                timer     <= '0;
            end else if (state == REQ) begin
                timer <= timer + TW'(1);
            end

            // Flags are only ever set on the edge into RESP, so they are
            // single-cycle pulses aligned with the RESP state.
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            tmo_q <= 1'b0;
            if (term) begin
                wbm_dat_o <= wbs_dat_i;
                err_q     <= wbs_err_i;
                rty_q     <= ~wbs_err_i & wbs_rty_i;
                ack_q     <= ~wbs_err_i & ~wbs_rty_i & wbs_ack_i;
            end else if (fire) begin
                err_q <= 1'b1;
                tmo_q <= 1'b1;
            end
        end
    end

    assign wbs_cyc_o = req_q;
    assign wbs_stb_o = req_q;
    assign wbs_cti_o = '0;
    assign wbs_bte_o = '0;

    // Terminations are withheld if the master has already left the cycle.
    assign wbm_ack_o = ack_q & wbm_cyc_i;
    assign wbm_err_o = err_q & wbm_cyc_i;
    assign wbm_rty_o = rty_q & wbm_cyc_i;
    assign timeout_o = tmo_q;

endmodule
